// File: rtl/brute_pkg.sv
// Shared ASCII constants, matcher state encoding and a letter-class helper.
package brute_pkg;

   localparam logic [7:0] ASCII_A        = 8'h61;
   localparam logic [7:0] ASCII_Z        = 8'h7A;
   localparam int         ALPHABET_SIZE  = 26;
   localparam int         ASCII_CASE_BIT = 5;

   typedef enum logic [1:0] {
      LOAD      = 2'd0,
      SEARCH    = 2'd1,
      FOUND     = 2'd2,
      EXHAUSTED = 2'd3
   } state_t;

   // Forcing the case bit high maps both 'A'..'Z' and 'a'..'z' onto 'a'..'z'.
   function automatic logic is_letter(input logic [7:0] c);
      logic [7:0] l;
      l = c | (8'd1 << ASCII_CASE_BIT);
      return (l >= ASCII_A) && (l <= ASCII_Z);
   endfunction

endpackage

// File: rtl/candidate_matcher_word_comparator.sv
// Combinational WORD_LEN-character equality; CANDIDATE_MATCHER_CASE_FOLD_EN folds letter case.
module word_comparator
   import brute_pkg::*;
#(
   parameter int WORD_LEN = 4
) (
   input  logic [8*WORD_LEN-1:0] i_target,
   input  logic [8*WORD_LEN-1:0] i_candidate,
   output logic                  o_eq
);

   logic [WORD_LEN-1:0] w_char_eq;

   for (genvar g = 0; g < WORD_LEN; g++) begin : g_char
      logic [7:0] w_t;
      logic [7:0] w_c;
      assign w_t = i_target[8*g +: 8];
      assign w_c = i_candidate[8*g +: 8];
`ifdef CANDIDATE_MATCHER_CASE_FOLD_EN
      // Only ignore the case bit when both sides are letters.
      logic [7:0] w_mask;
      assign w_mask = (is_letter(w_t) && is_letter(w_c)) ?
                      ~(8'd1 << ASCII_CASE_BIT) : 8'hFF;
      assign w_char_eq[g] = ((w_t ^ w_c) & w_mask) == 8'h00;
`else
      assign w_char_eq[g] = (w_t == w_c);
`endif
   end

   assign o_eq = &w_char_eq;

endmodule

// File: rtl/candidate_matcher.sv
// Byte-serial target load, two-stage candidate compare, attempt counting.
// Optional macro CANDIDATE_MATCHER_CASE_FOLD_EN enables case-insensitive letter compare.
module candidate_matcher
   import brute_pkg::*;
#(
   parameter int WORD_LEN = 4,
   parameter int CNT_W    = 32
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_load_valid,
   input  logic [7:0]            i_load_char,
   output logic                  o_load_ready,
   input  logic                  i_cand_valid,
   input  logic [8*WORD_LEN-1:0] i_cand_word,
   input  logic                  i_cand_last,
   output logic                  o_cand_ready,
   input  logic                  i_restart,
   output logic                  o_match_found,
   output logic [8*WORD_LEN-1:0] o_match_word,
   output logic [CNT_W-1:0]      o_attempts,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_LEN - 1);

   state_t                       r_state;
   state_t                       w_state_next;
   logic [IDX_W-1:0]             r_idx;
   logic [WORD_LEN-1:0][7:0]     r_target;
   logic                         r_pipe_valid;
   logic [8*WORD_LEN-1:0]        r_pipe_word;
   logic                         r_pipe_last;
   logic                         r_last_seen;
   logic                         r_match_found;
   logic                         r_done;
   logic [8*WORD_LEN-1:0]        r_match_word;
   logic [CNT_W-1:0]             r_attempts;
   logic                         w_eq;
   logic                         w_load_xfer;
   logic                         w_cand_xfer;

   word_comparator #(.WORD_LEN(WORD_LEN)) u_cmp (
      .i_target    (r_target),
      .i_candidate (r_pipe_word),
      .o_eq        (w_eq)
   );

   // Ready depends only on state, never on the valid inputs.
   always_comb begin
      o_load_ready = 1'b0;
      o_cand_ready = 1'b0;
      o_busy       = 1'b0;
      w_state_next = r_state;
      case (r_state)
         LOAD: begin
            o_load_ready = 1'b1;
            if (i_load_valid && r_idx == IDX_LAST) w_state_next = SEARCH;
         end
         SEARCH: begin
            o_busy       = 1'b1;
            o_cand_ready = !r_last_seen;
            if (r_pipe_valid) begin
               if (w_eq)             w_state_next = FOUND;
               else if (r_pipe_last) w_state_next = EXHAUSTED;
            end
         end
         FOUND, EXHAUSTED: begin
            if (i_restart) w_state_next = LOAD;
         end
         default: w_state_next = LOAD;
      endcase
   end

   assign w_load_xfer = i_load_valid && o_load_ready;
   assign w_cand_xfer = i_cand_valid && o_cand_ready;

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= LOAD;
      else         r_state <= w_state_next;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_idx         <= '0;
         r_target      <= {WORD_LEN{ASCII_A}};
         r_pipe_valid  <= 1'b0;
         r_pipe_word   <= '0;
         r_pipe_last   <= 1'b0;
         r_last_seen   <= 1'b0;
         r_match_found <= 1'b0;
         r_done        <= 1'b0;
         r_match_word  <= '0;
         r_attempts    <= '0;
      end else begin
         case (r_state)
            LOAD: begin
               r_pipe_valid <= 1'b0;
               if (w_load_xfer) begin
                  r_target[r_idx] <= i_load_char;
                  r_idx           <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
               end
            end
            SEARCH: begin
               r_pipe_valid <= w_cand_xfer;
               if (w_cand_xfer) begin
                  r_pipe_word <= i_cand_word;
                  r_pipe_last <= i_cand_last;
                  if (i_cand_last) r_last_seen <= 1'b1;
               end
               if (r_pipe_valid) begin
                  if (r_attempts != '1) r_attempts <= r_attempts + CNT_W'(1);
                  // A hit takes priority over last; stage-1 occupant is dropped.
                  if (w_eq) begin
                     r_match_found <= 1'b1;
                     r_match_word  <= r_pipe_word;
                     r_pipe_valid  <= 1'b0;
                  end else if (r_pipe_last) begin
                     r_done       <= 1'b1;
                     r_pipe_valid <= 1'b0;
                  end
               end
            end
            FOUND, EXHAUSTED: begin
               if (i_restart) begin
                  r_match_found <= 1'b0;
                  r_done        <= 1'b0;
                  r_attempts    <= '0;
                  r_pipe_valid  <= 1'b0;
                  r_idx         <= '0;
                  r_last_seen   <= 1'b0;
               end
            end
            default: r_pipe_valid <= 1'b0;
         endcase
      end
   end

   assign o_match_found = r_match_found;
   assign o_match_word  = r_match_word;
   assign o_attempts    = r_attempts;
   assign o_done        = r_done;

endmodule

// File: tb/tb_candidate_matcher.sv
// Self-checking bench for candidate_matcher: vector table with scoreboard plus corner sequences.
module tb_candidate_matcher;

   localparam int WL = 4;
   localparam int CW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            load_valid = 1'b0;
   logic [7:0]      load_char = 8'h00;
   logic            load_ready;
   logic            cand_valid = 1'b0;
   logic [8*WL-1:0] cand_word = '0;
   logic            cand_last = 1'b0;
   logic            cand_ready;
   logic            restart = 1'b0;
   logic            match_found;
   logic [8*WL-1:0] match_word;
   logic [CW-1:0]   attempts;
   logic            busy;
   logic            done;

   int total = 0;
   int bad   = 0;

   candidate_matcher #(.WORD_LEN(WL), .CNT_W(CW)) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_load_valid (load_valid),
      .i_load_char  (load_char),
      .o_load_ready (load_ready),
      .i_cand_valid (cand_valid),
      .i_cand_word  (cand_word),
      .i_cand_last  (cand_last),
      .o_cand_ready (cand_ready),
      .i_restart    (restart),
      .o_match_found(match_found),
      .o_match_word (match_word),
      .o_attempts   (attempts),
      .o_busy       (busy),
      .o_done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      string tgt;
      string cand;
      bit    last;
      bit    exp_found;
      bit    exp_done;
   } vec_t;

   typedef struct {
      string         name;
      bit            found;
      bit            done;
      logic [CW-1:0] att;
      logic [8*WL-1:0] word;
   } exp_t;

   exp_t sb[$];

   function automatic logic [8*WL-1:0] mk(input string s);
      logic [8*WL-1:0] v;
      v = '0;
      for (int i = 0; i < WL; i++) v[8*i +: 8] = s.getc(i);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic load(input string s);
      for (int i = 0; i < WL; i++) begin
         load_valid = 1'b1;
         load_char  = s.getc(i);
         tick();
      end
      load_valid = 1'b0;
   endtask

   task automatic send(input string s, input bit last);
      cand_valid = 1'b1;
      cand_word  = mk(s);
      cand_last  = last;
      tick();
      cand_valid = 1'b0;
      cand_last  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      exp_t e;
      bit   ok;
      bit   fold_hit;
`ifdef CANDIDATE_MATCHER_CASE_FOLD_EN
      fold_hit = 1'b1;
`else
      fold_hit = 1'b0;
`endif
      vecs[0] = '{"prio",    "zzzz", "zzzz", 1'b1, 1'b1, 1'b0};
      vecs[1] = '{"miss",    "abcd", "abce", 1'b1, 1'b0, 1'b1};
      vecs[2] = '{"fold",    "AbCd", "abcd", 1'b1, fold_hit, !fold_hit};
      vecs[3] = '{"digits",  "a1b2", "a1b2", 1'b0, 1'b1, 1'b0};
      vecs[4] = '{"nonlet",  "[[[[", "{{{{", 1'b1, 1'b0, 1'b1};
      vecs[5] = '{"char0",   "qrst", "xrst", 1'b1, 1'b0, 1'b1};

      // Reset state and basic back-to-back stream
      do_reset();
      chk("rst_load_ready", 64'(load_ready), 64'd1);
      chk("rst_cand_ready", 64'(cand_ready), 64'd0);
      chk("rst_busy",       64'(busy),       64'd0);
      chk("rst_found",      64'(match_found),64'd0);
      chk("rst_done",       64'(done),       64'd0);
      chk("rst_attempts",   64'(attempts),   64'd0);
      chk("rst_word",       64'(match_word), 64'd0);
      load("abcd");
      chk("search_busy",  64'(busy),       64'd1);
      chk("search_ready", 64'(cand_ready), 64'd1);
      chk("search_lready",64'(load_ready), 64'd0);
      send("aaaa", 1'b0);
      send("abcc", 1'b0);
      send("abcd", 1'b0);
      chk("lat_not_yet", 64'(match_found), 64'd0);
      send("abce", 1'b0);
      chk("lat_found", 64'(match_found), 64'd1);
      tick();
      chk("seq1_attempts", 64'(attempts),   64'd3);
      chk("seq1_word",     64'(match_word), 64'(mk("abcd")));
      chk("seq1_cready",   64'(cand_ready), 64'd0);
      chk("seq1_busy",     64'(busy),       64'd0);

      // Exhaustion with cand_last
      do_reset();
      load("zzzz");
      send("zzza", 1'b0);
      send("zzzb", 1'b1);
      chk("exh_cready_drop", 64'(cand_ready), 64'd0);
      chk("exh_not_yet",     64'(done),       64'd0);
      tick();
      chk("exh_done",     64'(done),        64'd1);
      chk("exh_found",    64'(match_found), 64'd0);
      chk("exh_attempts", 64'(attempts),    64'd2);

      // Reset during the third load byte
      do_reset();
      load_valid = 1'b1; load_char = "x"; tick();
      load_char = "y"; tick();
      load_char = "z"; rst = 1'b1; tick();
      rst = 1'b0; load_valid = 1'b0;
      chk("midrst_lready", 64'(load_ready), 64'd1);
      chk("midrst_busy",   64'(busy),       64'd0);
      load("dcba");
      send("dcba", 1'b0);
      tick();
      chk("midrst_found",    64'(match_found), 64'd1);
      chk("midrst_attempts", 64'(attempts),    64'd1);

      // Frozen in FOUND, then restart
      send("zzzz", 1'b0);
      tick();
      chk("frozen_attempts", 64'(attempts), 64'd1);
      restart = 1'b1; tick(); restart = 1'b0;
      chk("rs_lready",   64'(load_ready),  64'd1);
      chk("rs_found",    64'(match_found), 64'd0);
      chk("rs_attempts", 64'(attempts),    64'd0);
      load("bbbb");
      restart = 1'b1; tick(); restart = 1'b0;
      chk("rs_ignored_busy", 64'(busy), 64'd1);
      send("bbbb", 1'b0);
      tick();
      chk("rs2_found",    64'(match_found), 64'd1);
      chk("rs2_attempts", 64'(attempts),    64'd1);

      // Table vectors through the scoreboard
      foreach (vecs[k]) begin
         do_reset();
         load(vecs[k].tgt);
         e.name  = vecs[k].name;
         e.found = vecs[k].exp_found;
         e.done  = vecs[k].exp_done;
         e.att   = CW'(1);
         e.word  = vecs[k].exp_found ? mk(vecs[k].cand) : '0;
         sb.push_back(e);
         send(vecs[k].cand, vecs[k].last);
         ok = 1'b0;
         for (int c = 0; c < 20; c++) begin
            if (match_found || done) begin
               ok = 1'b1;
               break;
            end
            tick();
         end
         e = sb.pop_front();
         if (!ok) chk({e.name, "_timeout"}, 64'd0, 64'd1);
         else begin
            chk({e.name, "_found"}, 64'(match_found), 64'(e.found));
            chk({e.name, "_done"},  64'(done),        64'(e.done));
            chk({e.name, "_att"},   64'(attempts),    64'(e.att));
            chk({e.name, "_word"},  64'(match_word),  64'(e.word));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
